// File: rtl/mag_cmp_seq_pkg.sv
// Shared definitions for the sequential magnitude comparator:
// relational mode codes, FSM state encoding, scan-index width helper
// and the mode-to-result selection function.
package cmp_pkg;

  localparam logic [2:0] CMP_EQ = 3'd0;
  localparam logic [2:0] CMP_NE = 3'd1;
  localparam logic [2:0] CMP_GT = 3'd2;
  localparam logic [2:0] CMP_GE = 3'd3;
  localparam logic [2:0] CMP_LT = 3'd4;
  localparam logic [2:0] CMP_LE = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Scan index width; never narrower than one bit, even for a single chunk.
  function automatic int idx_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Reserved modes (6/7) always report 0.
  function automatic logic rel_sel(input logic [2:0] mode, input logic eq,
                                   input logic gt, input logic lt);
    logic r;
    r = 1'b0;
    case (mode)
      CMP_EQ:  r = eq;
      CMP_NE:  r = ~eq;
      CMP_GT:  r = gt;
      CMP_GE:  r = gt | eq;
      CMP_LT:  r = lt;
      CMP_LE:  r = lt | eq;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mag_cmp_seq_if.sv
// Request/response bundle of the sequential magnitude comparator.
// master = requester (ALU sequencer or bench), slave = comparator.
interface mag_cmp_seq_if #(
  parameter int W = 6
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   mode;
  logic         is_signed;
  logic         busy;
  logic         done;
  logic         eq;
  logic         gt;
  logic         lt;
  logic         result;
  logic [W-1:0] out;

  modport master (
    output start, a, b, mode, is_signed,
    input  busy, done, eq, gt, lt, result, out
  );

  modport slave (
    input  start, a, b, mode, is_signed,
    output busy, done, eq, gt, lt, result, out
  );
endinterface

// File: rtl/mag_cmp_seq_chunk.sv
// Combinational unsigned compare of one CHUNK-bit operand slice.
// Both outputs low means the slices are equal.
module cmp_chunk #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             c_gt,
  output logic             c_lt
);

  assign c_gt = (x > y);
  assign c_lt = (x < y);

endmodule

// File: rtl/mag_cmp_seq.sv
// Multi-cycle magnitude comparator, MSB chunk first, CHUNK bits per clock.
// Build option: MAG_CMP_EARLY_EXIT_EN -- when defined, the scan stops on the
// first unequal chunk; otherwise every chunk is visited (fixed latency) and
// the first unequal chunk seen is held as the decision.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; operands not yet latched
// ST_SCAN | comparing chunk idx of the latched operands, busy high
// ST_DONE | flags valid; done pulses on leaving; start accepted here too
module mag_cmp_seq
  import cmp_pkg::*;
#(
  parameter int W     = 6,
  parameter int CHUNK = 2
) (
  input logic          clk,
  input logic          reset_n,
  mag_cmp_seq_if.slave bus
);

  localparam int NCH = W / CHUNK;
  localparam int IW  = idx_w(NCH);

  state_t         state;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2:0]     mode_q;
  logic [IW-1:0]  idx;
  logic           busy_q;
  logic           done_q;
  logic           eq_q;
  logic           gt_q;
  logic           lt_q;
  logic           res_q;

  logic [CHUNK-1:0] x_sl;
  logic [CHUNK-1:0] y_sl;
  logic             c_gt;
  logic             c_lt;
  logic             dec_gt;
  logic             dec_lt;
  logic             scan_last;

  // Flipping the sign bit maps two's complement onto offset binary, so the
  // unsigned chunk compare yields signed order without a separate path.
  logic [W-1:0] sign_mask;
  assign sign_mask = {bus.is_signed, {(W-1){1'b0}}};

  assign x_sl = a_q[idx*CHUNK +: CHUNK];
  assign y_sl = b_q[idx*CHUNK +: CHUNK];

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .x    (x_sl),
    .y    (y_sl),
    .c_gt (c_gt),
    .c_lt (c_lt)
  );

`ifdef MAG_CMP_EARLY_EXIT_EN
  assign dec_gt    = c_gt;
  assign dec_lt    = c_lt;
  assign scan_last = c_gt | c_lt | (idx == '0);
`else
  logic pend_gt;
  logic pend_lt;

  // Once a higher chunk has decided, lower chunks must not override it.
  assign dec_gt    = (pend_gt | pend_lt) ? pend_gt : c_gt;
  assign dec_lt    = (pend_gt | pend_lt) ? pend_lt : c_lt;
  assign scan_last = (idx == '0);

  // Capture the first unequal chunk of the current scan.
  always_ff @(posedge clk) begin
    if (!reset_n || state != ST_SCAN) begin
      pend_gt <= 1'b0;
      pend_lt <= 1'b0;
    end else begin
      pend_gt <= dec_gt;
      pend_lt <= dec_lt;
    end
  end
`endif

  // Sequencing FSM with operand latch and registered result flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
      idx    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      eq_q   <= 1'b0;
      gt_q   <= 1'b0;
      lt_q   <= 1'b0;
      res_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (state == ST_DONE) done_q <= 1'b1;
          if (bus.start) begin
            a_q    <= bus.a ^ sign_mask;
            b_q    <= bus.b ^ sign_mask;
            mode_q <= bus.mode;
            idx    <= IW'(NCH - 1);
            busy_q <= 1'b1;
            state  <= ST_SCAN;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (scan_last) begin
            gt_q   <= dec_gt;
            lt_q   <= dec_lt;
            eq_q   <= ~(dec_gt | dec_lt);
            res_q  <= rel_sel(mode_q, ~(dec_gt | dec_lt), dec_gt, dec_lt);
            busy_q <= 1'b0;
            state  <= ST_DONE;
          end else begin
            idx    <= idx - 1'b1;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.eq     = eq_q;
  assign bus.gt     = gt_q;
  assign bus.lt     = lt_q;
  assign bus.result = res_q;
  assign bus.out    = {{(W-1){1'b0}}, res_q};

endmodule

// File: tb/tb_mag_cmp_seq.sv
// Scoreboard bench for mag_cmp_seq (W=6, CHUNK=2): directed vectors push
// hand-computed expectations; a monitor pops and compares on each done.
module tb_mag_cmp_seq;
  import cmp_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mag_cmp_seq_if #(.W(6)) bus ();

  mag_cmp_seq #(.W(6), .CHUNK(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string name;
    logic  eq;
    logic  gt;
    logic  lt;
    logic  res;
    int    lat;
    int    start_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t got;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (reset_n && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        got = sb.pop_front();
        chk({got.name, "_eq"}, int'(bus.eq), int'(got.eq));
        chk({got.name, "_gt"}, int'(bus.gt), int'(got.gt));
        chk({got.name, "_lt"}, int'(bus.lt), int'(got.lt));
        chk({got.name, "_res"}, int'(bus.result), int'(got.res));
        chk({got.name, "_out"}, int'(bus.out), int'({5'b0, got.res}));
        chk({got.name, "_lat"}, cyc - got.start_cyc, got.lat);
      end
    end
  end

  // Called at a negedge; returns at the following negedge with start low.
  task automatic issue(input string nm, input logic [5:0] av, input logic [5:0] bv,
                       input logic [2:0] md, input logic sg,
                       input logic e_eq, input logic e_gt, input logic e_lt,
                       input logic e_res, input int lat_early);
    exp_t e;
    bus.a = av;
    bus.b = bv;
    bus.mode = md;
    bus.is_signed = sg;
    bus.start = 1'b1;
    e.name = nm;
    e.eq = e_eq;
    e.gt = e_gt;
    e.lt = e_lt;
    e.res = e_res;
`ifdef MAG_CMP_EARLY_EXIT_EN
    e.lat = lat_early;
`else
    e.lat = 4;
`endif
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_busy"}, int'(bus.busy), 0);
    chk({nm, "_done"}, int'(bus.done), 0);
    chk({nm, "_eq"}, int'(bus.eq), 0);
    chk({nm, "_gt"}, int'(bus.gt), 0);
    chk({nm, "_lt"}, int'(bus.lt), 0);
    chk({nm, "_res"}, int'(bus.result), 0);
    chk({nm, "_out"}, int'(bus.out), 0);
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.mode = '0;
    bus.is_signed = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    //    name        a          b          mode    sg  eq gt lt res lat
    issue("t1_ge",   6'b101100, 6'b011111, CMP_GE, 0,  0, 1, 0, 1, 2); wait_idle();
    issue("t2_eq",   6'd45,     6'd45,     CMP_EQ, 0,  1, 0, 0, 1, 4); wait_idle();
    issue("t2_lt",   6'd45,     6'd45,     CMP_LT, 0,  1, 0, 0, 0, 4); wait_idle();
    issue("t3_slt",  6'b111111, 6'b000001, CMP_LT, 1,  0, 0, 1, 1, 2); wait_idle();
    issue("t3_ult",  6'b111111, 6'b000001, CMP_LT, 0,  0, 1, 0, 0, 2); wait_idle();
    issue("t4_gt",   6'b010110, 6'b010101, CMP_GT, 0,  0, 1, 0, 1, 4); wait_idle();
    issue("sne_eq",  6'b100000, 6'b100000, CMP_NE, 1,  1, 0, 0, 0, 4); wait_idle();
    issue("ule_gt",  6'b000010, 6'b000001, CMP_LE, 0,  0, 1, 0, 0, 4); wait_idle();
    issue("sgt_mid", 6'b000100, 6'b110100, CMP_GT, 1,  0, 1, 0, 1, 1 + 1); wait_idle();

    // Start pulse during SCAN must be ignored.
    issue("t5_base", 6'd45, 6'd45, CMP_EQ, 0, 1, 0, 0, 1, 4);
    bus.a = 6'd0;
    bus.b = 6'd63;
    bus.mode = CMP_GT;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (6) @(negedge clk);

    // Reset mid-SCAN discards the compare and clears all outputs.
    bus.a = 6'd9;
    bus.b = 6'd9;
    bus.mode = CMP_EQ;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t5_busy_scan", int'(bus.busy), 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk_all_zero("t5_rst");
    reset_n = 1'b1;
    repeat (6) @(negedge clk);

    // Reserved mode, then back-to-back start issued in the DONE cycle.
    issue("t6_rsv", 6'b100000, 6'b000001, 3'd6, 0, 0, 1, 0, 0, 2);
    n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_busy_timeout", int'(bus.busy), 0);
    issue("t6_b2b", 6'b000100, 6'b000111, CMP_LE, 0, 0, 0, 1, 1, 4);
    wait_idle();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
